// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit beside the execute-stage ALU
// Ports: clk, rst_n (sync, active-low); start_i/funct3_i/op1_i/op2_i accept one op in IDLE;
// flush_i aborts; busy_o = not IDLE; stall_o freezes IF/ID/EX; done_o pulses with result_o.
// Optional MULDIV_FAST_MUL_EN: multiply ops finish in one step on a combinational multiplier.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2*XLEN-1:0] acc, acc_nxt, prod;
  logic [XLEN-1:0] b, m1, m2, spec_res, dif, quo, rem, fin;
  logic [XLEN:0] madd, shl;
  logic [2:0] f3;
  logic neg_q, neg_r, is_div, sg1, sg2, n1, n2, div0, ovf, ge;
  assign is_div = funct3_i[2];
  assign sg1 = is_div ? ~funct3_i[0] : funct3_i[0] ^ funct3_i[1];
  assign sg2 = is_div ? ~funct3_i[0] : funct3_i[1:0] == 2'b01;
  assign n1 = sg1 & op1_i[XLEN-1];
  assign n2 = sg2 & op2_i[XLEN-1];
  // magnitude of the most negative value wraps to itself and is treated as unsigned
  assign m1 = n1 ? -op1_i : op1_i;
  assign m2 = n2 ? -op2_i : op2_i;
  assign div0 = is_div & (op2_i == '0);
  assign ovf = is_div & ~funct3_i[0] & (op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&op2_i);
  assign spec_res = div0 ? (funct3_i[1] ? op1_i : '1) : (funct3_i[1] ? '0 : op1_i);
  // acc holds the product for multiplies and {remainder, quotient} for divides
  assign madd = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b} : '0);
  assign shl = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign ge = shl >= {1'b0, b};
  // remainder stays below the divisor, so the low XLEN bits of the difference suffice
  assign dif = shl[XLEN-1:0] - b;
  assign acc_nxt = f3[2] ? {ge ? dif : shl[XLEN-1:0], acc[XLEN-2:0], ge} : {madd, acc[XLEN-1:1]};
  // final result is formed from the last iteration so it is registered on entry to DONE
  assign prod = neg_q ? -acc_nxt : acc_nxt;
  assign quo = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
  assign rem = neg_r ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
  assign fin = f3[2] ? (f3[1] ? rem : quo) : (f3[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fm;
  logic [XLEN-1:0] fast_res;
  assign fm = {{XLEN{n1}}, op1_i} * {{XLEN{n2}}, op2_i};
  assign fast_res = funct3_i[1:0] == 2'b00 ? fm[XLEN-1:0] : fm[2*XLEN-1:XLEN];
`endif
  assign busy_o = state != IDLE;
  assign stall_o = (start_i & (state == IDLE)) | (state == CALC);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      b <= '0;
      f3 <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      done_o <= 1'b0;
      result_o <= '0;
    end else begin
      done_o <= 1'b0;
      if (flush_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (start_i) begin
            f3 <= funct3_i;
            neg_q <= n1 ^ n2;
            neg_r <= n1;
            cnt <= CW'(XLEN);
            acc <= {{XLEN{1'b0}}, is_div ? m1 : m2};
            b <= is_div ? m2 : m1;
            if (div0 | ovf) begin
              result_o <= spec_res;
              done_o <= 1'b1;
              state <= DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!is_div) begin
              result_o <= fast_res;
              done_o <= 1'b1;
              state <= DONE;
            end
`endif
            else state <= CALC;
          end
          CALC: begin
            acc <= acc_nxt;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              result_o <= fin;
              done_o <= 1'b1;
              state <= DONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: vector table, random ops vs arithmetic model, flush/reset corner sequences
module tb_muldiv_sequencer;
  logic clk = 0, rst_n = 0, start = 0, flush = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] op1 = 0, op2 = 0, result;
  logic busy, stall, done;
  int tests = 0, fails = 0;
  logic [31:0] last_exp = 0;
  always #5 clk = ~clk;
  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .funct3_i(funct3), .op1_i(op1), .op2_i(op2),
    .flush_i(flush), .busy_o(busy), .stall_o(stall), .done_o(done), .result_o(result)
  );
  typedef struct {
    logic [2:0] f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[13];
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa = {{32{a[31]}}, a};
    longint ua = {32'b0, a};
    longint sb = {{32{b[31]}}, b};
    longint ub = {32'b0, b};
    logic [63:0] p;
    logic [31:0] r;
    case (f)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : $signed(a) / $signed(b);
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: r = (b == 0) ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 : $signed(a) % $signed(b);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction
  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 33;
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    int lat = 0;
    logic stall_ok = 1;
    @(negedge clk);
    start = 1; funct3 = f; op1 = a; op2 = b;
    #1 if (!stall) stall_ok = 0;
    do begin
      @(posedge clk);
      #1 start = 0;
      lat++;
      if (!done && !(stall && busy)) stall_ok = 0;
    end while (!done && lat < 100);
    chk({nm, "_result"}, result, exp);
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat(f, a, b)));
    chk({nm, "_stall"}, {31'b0, stall_ok}, 32'd1);
    @(posedge clk);
    #1 chk({nm, "_pulse"}, {31'b0, done}, 32'd0);
    last_exp = exp;
  endtask
  task automatic no_done(input string nm, input int n);
    logic seen = 0;
    repeat (n) begin
      @(posedge clk);
      #1 if (done) seen = 1;
    end
    chk(nm, {31'b0, seen}, 32'd0);
  endtask
  initial begin
    tbl[0]  = '{3'd0, 32'd7, 32'd6, 32'h0000002A};
    tbl[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000};
    tbl[2]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[3]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    tbl[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD};
    tbl[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF};
    tbl[6]  = '{3'd5, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF};
    tbl[7]  = '{3'd7, 32'd100, 32'd7, 32'd2};
    tbl[8]  = '{3'd4, 32'd5, 32'd0, 32'hFFFFFFFF};
    tbl[9]  = '{3'd6, 32'd5, 32'd0, 32'd5};
    tbl[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    tbl[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0};
    tbl[12] = '{3'd5, 32'd5, 32'd0, 32'hFFFFFFFF};
    repeat (2) @(posedge clk);
    #1 chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_stall", {31'b0, stall}, 32'd0);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 13; i++) do_op($sformatf("vec%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].exp);
    for (int i = 0; i < 40; i++) begin
      logic [2:0] f = 3'($urandom_range(0, 7));
      logic [31:0] a = pick();
      logic [31:0] b = pick();
      do_op($sformatf("rand%0d_f%0d", i, f), f, a, b, model(f, a, b));
    end
    @(negedge clk);
    start = 1; funct3 = 3'd7; op1 = 32'd100; op2 = 32'd7;
    @(posedge clk);
    #1 start = 0;
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1;
    @(posedge clk);
    #1 chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_done", {31'b0, done}, 32'd0);
    chk("flush_result_held", result, last_exp);
    flush = 0;
    no_done("flush_no_done", 40);
    do_op("after_flush_divu", 3'd5, 32'd9, 32'd3, 32'd3);
    @(negedge clk);
    start = 1; funct3 = 3'd0; op1 = 32'd7; op2 = 32'd6;
    @(posedge clk);
    #1 start = 0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 0;
    @(posedge clk);
    #1 chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_stall", {31'b0, stall}, 32'd0);
    @(negedge clk) rst_n = 1;
    no_done("midrst_no_done", 40);
    @(negedge clk);
    start = 1; flush = 1; funct3 = 3'd4; op1 = 32'd5; op2 = 32'd0;
    @(posedge clk);
    #1 chk("start_flush_busy", {31'b0, busy}, 32'd0);
    chk("start_flush_done", {31'b0, done}, 32'd0);
    start = 0; flush = 0;
    no_done("start_flush_no_done", 5);
    do_op("final_mul", 3'd0, 32'd7, 32'd6, 32'h0000002A);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
